// File: rtl/gf2m_pkg.sv
// Shared definitions for the GF(2^M) arithmetic blocks: FSM states,
// standard irreducible polynomials and a counter-width helper.
package gf2m_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] GF2_POLY_M2 = 3'b111;
    localparam logic [4:0] GF2_POLY_M4 = 5'b10011;
    localparam logic [8:0] GF2_POLY_M8 = 9'h11B;

    // Bits needed to index any coefficient of a 2M-1 bit unreduced product.
    function automatic int cnt_width(input int m);
        return $clog2(2 * m - 1);
    endfunction

endpackage

// File: rtl/gf2m_poly_reducer_if.sv
// Valid/ready bundle carrying an unreduced product in and a reduced field element out.
interface gf2m_poly_reducer_if #(
    parameter int M = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [2*M-2:0]   c;
    logic             out_valid;
    logic             out_ready;
    logic [M-1:0]     y;

    modport master (
        output in_valid, c, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, c, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/gf2m_reduce_step.sv
// One bit-serial reduction step: clears coefficient j of r by folding in POLY << (j-M).
module gf2m_reduce_step
    import gf2m_pkg::*;
#(
    parameter int         M    = 2,
    parameter logic [M:0] POLY = GF2_POLY_M2,
    localparam int        W    = 2 * M - 1,
    localparam int        JW   = cnt_width(M)
) (
    input  logic [W-1:0]  r,
    input  logic [JW-1:0] j,
    output logic [W-1:0]  r_next
);

    logic [W-1:0] poly_ext;
    assign poly_ext = W'(POLY);

    // NOTE: r_next gets a default before the conditional update so no latch is inferred.
    always_comb begin
        r_next = r;
        if (r[j]) begin
            r_next = r ^ (poly_ext << (j - JW'(M)));
        end
    end

endmodule

// File: rtl/gf2m_poly_reducer.sv
// Bit-serial modular reducer: takes a 2M-1 bit carry-less product and returns it mod POLY
// after a fixed M-1 cycle RUN phase, with valid/ready on both sides.
module gf2m_poly_reducer
    import gf2m_pkg::*;
#(
    parameter int         M    = 2,
    parameter logic [M:0] POLY = GF2_POLY_M2
) (
    input  logic                   clk,
    input  logic                   rst,
    gf2m_poly_reducer_if.slave     bus,
    output logic                   busy
);

    localparam int W  = 2 * M - 1;
    localparam int JW = cnt_width(M);

    generate
        if (M < 2 || POLY[M] !== 1'b1) begin : g_bad_param
            $fatal(1, "gf2m_poly_reducer: need M >= 2 and POLY[M] = 1");
        end
    endgenerate

    state_e        state, state_d;
    logic [W-1:0]  r, r_d, r_step;
    logic [JW-1:0] j, j_d;

    gf2m_reduce_step #(.M(M), .POLY(POLY)) u_step (
        .r      (r),
        .j      (j),
        .r_next (r_step)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            r     <= '0;
            j     <= '0;
        end else begin
            state <= state_d;
            r     <= r_d;
            j     <= j_d;
        end
    end

    always_comb begin
        state_d = state;
        r_d     = r;
        j_d     = j;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    r_d     = bus.c;
                    j_d     = JW'(2 * M - 2);
                    state_d = RUN;
                end
            end
            RUN: begin
                r_d = r_step;
                j_d = j - JW'(1);
                if (j == JW'(M)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.y         = r[M-1:0];
    assign busy          = (state != IDLE);

    // Every high coefficient is cleared by the step that tests it.
    a_high_clear: assert property (@(posedge clk) disable iff (rst)
        (state == DONE) |-> (r[W-1:M] == '0));

endmodule
